control_multiciclo: RTL
=======================

Name: control_multiciclo

Overview:
Main control FSM for the multicycle MIPS32 datapath. It is the producer side of the ALUop interface and drives ALUop plus every datapath strobe and mux select, one instruction step per state. Memory accesses use a mem_ready handshake with a bounded wait timeout.

Parameters:
MEM_TIMEOUT, 15, maximum consecutive cycles without mem_ready in any memory state before mem_err; 0 disables the timeout.
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high (already decided).
opcode  in  6  instruction bits [31:26], taken from the IR.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completed the current access this cycle.
ALUop  out  2  00 add, 01 sub (beq), 10 R-type funct, 11 I-type.
fnc_sel  out  1  1 routes opcode (not funct) to the ALU control function input.
pc_en  out  1  PCWrite OR (PCWriteCond AND zero).
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
IorD  out  1  0 PC address, 1 ALUOut address.
MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA  out  1 each  standard multicycle strobes and selects.
ALUSrcB  out  2  00 B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
mem_err  out  1  one-cycle pulse on memory timeout.
estado  out  4  current state, for debug.

Behaviour:
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11. Codes 12-15 are unreachable and go to FETCH.
- Outputs are Moore-decoded from the state. Strobes in FETCH, MEM_READ and MEM_WRITE are additionally gated by mem_ready where stated.
- Reset: on a clk edge with rst=1, estado←FETCH and the wait counter←0. While rst=1, all outputs are forced to 0 and ALUop to 00. Reset in any state aborts the instruction; no partial writes occur.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00. IRWrite and PCWrite (pc_en) are asserted only when mem_ready=1. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut). Next state by opcode:
  - 100011/101011 → MEM_ADDR
  - 000000 → R_EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000/001100/001101/001110/001010 → I_EXEC
  - any other opcode → FETCH with illegal_op=1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Goes to MEM_READ if opcode[3]=0, otherwise MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Goes to FETCH.
- MEM_WRITE: IorD=1, MemWrite=1 is held until the cycle mem_ready=1. In that cycle instr_done=1 and the next state is FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Goes to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, so pc_en=zero. instr_done=1. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Goes to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUop=11, fnc_sel=1. Goes to I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Goes to FETCH.
- Latency with mem_ready tied to 1: lw 5 cycles, sw 4, R-type 4, I-type 4, beq 3, j 3.
- Wait counter:
  - Increments each cycle a memory state sees mem_ready=0, and clears on state exit.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT with mem_ready still 0, mem_err pulses, all strobes drop that cycle, and the next state is FETCH. There is no IR or PC write and no instr_done.
  - mem_ready=1 in the timeout cycle takes priority: the access completes normally.
- Opcode is sampled only in DECODE and MEM_ADDR; the IR is stable in those states.

Decomposition:
- Shared package/header ctrl_defs: state encodings, opcode constants, ALUop codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_R=10, ALUOP_I=11), ALUSrcB and PCSource encodings.
- One sub-module, control_salidas: pure combinational state+mem_ready+zero → output decode. The FSM register, next-state logic and wait counter stay in control_multiciclo.

Test Plan:
- Reset, then mem_ready=1 and opcode=000000 → estado 0,1,6,7,0. ALUop=10 in R_EXEC; RegWrite=1 and RegDst=1 in R_WB; instr_done pulses only in the R_WB cycle.
- opcode=100011, mem_ready low for 3 cycles in MEM_READ → lw takes 8 cycles. MemRead and IorD=1 are held throughout; RegWrite=1 and MemtoReg=1 for exactly one cycle.
- opcode=000100, zero=1 then a second beq with zero=0 → ALUop=01 in BRANCH. pc_en=1 for the first and 0 for the second; each instruction takes 3 cycles.
- opcode=001101 (ori) → fnc_sel=1 and ALUop=11 only in I_EXEC; RegDst=0 in I_WB.
- opcode=111111 in DECODE → illegal_op pulses once and the next state is FETCH; RegWrite and MemWrite are never asserted.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH → mem_err pulses on the 16th FETCH cycle with IRWrite=0 and estado back to FETCH. Asserting rst mid-MEM_WRITE forces all outputs to 0 and estado to 0 on the next edge.

Source files
------------

// File: rtl/ctrl_defs_pkg.sv
// rtl/ctrl_defs_pkg.sv - shared encodings for the multicycle MIPS control FSM
package ctrl_defs;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_R_EXEC    = 4'd6,
      ST_R_WB      = 4'd7,
      ST_BRANCH    = 4'd8,
      ST_JUMP      = 4'd9,
      ST_I_EXEC    = 4'd10,
      ST_I_WB      = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Unsupported opcodes map to FETCH, which is also how DECODE flags them illegal.
   function automatic state_t decode_next(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW:                              return ST_MEM_ADDR;
         OP_RTYPE:                                  return ST_R_EXEC;
         OP_BEQ:                                    return ST_BRANCH;
         OP_J:                                      return ST_JUMP;
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: return ST_I_EXEC;
         default:                                   return ST_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/control_salidas.sv
// rtl/control_salidas.sv - Moore output decode of the control FSM, gated by mem_ready
module control_salidas
   import ctrl_defs::*;
(
   input  logic [3:0] estado,
   input  logic       mem_ready,
   input  logic       zero,
   input  logic       abort,
   output logic [1:0] ALUop,
   output logic       fnc_sel,
   output logic       pc_en,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       instr_done
);

   always_comb begin
      ALUop      = ALUOP_ADD;
      fnc_sel    = 1'b0;
      pc_en      = 1'b0;
      PCSource   = PCSRC_ALU;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_B;
      instr_done = 1'b0;
      // abort covers reset and the memory timeout cycle: nothing may be written
      if (!abort) begin
         case (estado)
            ST_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_FOUR;
               IRWrite = mem_ready;
               pc_en   = mem_ready;
            end
            ST_DECODE:   ALUSrcB = SRCB_IMM2;
            ST_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            ST_MEM_READ: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            ST_MEM_WB: begin
               RegWrite   = 1'b1;
               MemtoReg   = 1'b1;
               instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
               IorD       = 1'b1;
               MemWrite   = 1'b1;
               instr_done = mem_ready;
            end
            ST_R_EXEC: begin
               ALUSrcA = 1'b1;
               ALUop   = ALUOP_R;
            end
            ST_R_WB: begin
               RegWrite   = 1'b1;
               RegDst     = 1'b1;
               instr_done = 1'b1;
            end
            ST_BRANCH: begin
               ALUSrcA    = 1'b1;
               ALUop      = ALUOP_SUB;
               PCSource   = PCSRC_ALUOUT;
               pc_en      = zero;
               instr_done = 1'b1;
            end
            ST_JUMP: begin
               pc_en      = 1'b1;
               PCSource   = PCSRC_JUMP;
               instr_done = 1'b1;
            end
            ST_I_EXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ALUop   = ALUOP_I;
               fnc_sel = 1'b1;
            end
            ST_I_WB: begin
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle MIPS32 main control FSM with memory wait timeout
module control_multiciclo
   import ctrl_defs::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [1:0] ALUop,
   output logic       fnc_sel,
   output logic       pc_en,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] estado
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mem_state;
   logic               timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      mem_state = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                  (state_q == ST_MEM_WRITE);
      timeout   = mem_state && !mem_ready && (MEM_TIMEOUT != 0) &&
                  (cnt_q == CNT_W'(MEM_TIMEOUT));
      case (state_q)
         ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
         ST_DECODE:    state_d = decode_next(opcode);
         ST_MEM_ADDR:  state_d = opcode[3] ? ST_MEM_WRITE : ST_MEM_READ;
         ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
         ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
         ST_R_EXEC:    state_d = ST_R_WB;
         ST_I_EXEC:    state_d = ST_I_WB;
         default:      state_d = ST_FETCH;
      endcase
      if (timeout) state_d = ST_FETCH;
      // counts only while parked in a memory state; any exit clears it
      if (mem_state && !mem_ready && !timeout && (state_d == state_q))
         cnt_d = cnt_q + CNT_W'(1);
   end

   assign illegal_op = !rst && (state_q == ST_DECODE) && (decode_next(opcode) == ST_FETCH);
   assign mem_err    = !rst && timeout;
   assign estado     = rst ? 4'd0 : state_q;

   control_salidas u_salidas (
      .estado     (state_q),
      .mem_ready  (mem_ready),
      .zero       (zero),
      .abort      (rst | timeout),
      .ALUop      (ALUop),
      .fnc_sel    (fnc_sel),
      .pc_en      (pc_en),
      .PCSource   (PCSource),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .instr_done (instr_done)
   );

endmodule
